// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory arbiter: FSM encoding,
// the abort return word and the timeout counter width.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;
  localparam int          ARB_TMR_W    = 8;

endpackage

// File: rtl/arb_wait_timer.sv
// Wait counter with clear/enable; o_expire flags the TIMEOUT-th enabled
// cycle so the caller can abort on that same edge.
module arb_wait_timer
  import arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [ARB_TMR_W-1:0] r_cnt;

  assign o_expire = i_en & (r_cnt == ARB_TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_cnt <= '0;
    else if (i_clr || o_expire) r_cnt <= '0;
    else if (i_en)              r_cnt <= r_cnt + ARB_TMR_W'(1);
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one variable-latency
// memory port, with a fetch starvation guard and a bus timeout.
module unified_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_ren,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_data,
  output logic              inst_ack,
  input  logic              mem_ren,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_ack,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stall,
  output logic              bus_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    r_state;
  logic [SW-1:0] r_starve;
  logic          w_ireq, w_dreq, w_grant_i, w_grant_d;
  logic          w_serve, w_expire, w_done;

  // A requester whose ack is showing this cycle is already satisfied.
  assign w_ireq    = inst_ren & ~inst_ack;
  assign w_dreq    = (mem_ren | mem_wen) & ~mem_ack;
  assign w_grant_i = w_ireq & (~w_dreq | (r_starve == SW'(STARVE_LIMIT)));
  assign w_grant_d = w_dreq & ~w_grant_i;
  assign w_serve   = (r_state == SERVE_I) || (r_state == SERVE_D);
  assign w_done    = w_serve & (bus_ack | w_expire);
  assign stall     = w_ireq | w_dreq;

  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (~w_serve | bus_ack),
    .i_en    (w_serve & ~bus_ack),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_starve  <= '0;
      inst_data <= '0;
      inst_ack  <= 1'b0;
      mem_din   <= '0;
      mem_ack   <= 1'b0;
      bus_cs    <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      inst_ack <= 1'b0;
      mem_ack  <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_i) begin
            bus_cs   <= 1'b1;
            bus_we   <= 1'b0;
            bus_addr <= inst_addr;
            r_starve <= '0;
            r_state  <= SERVE_I;
          end else if (w_grant_d) begin
            bus_cs    <= 1'b1;
            bus_we    <= mem_wen;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_dout;
            if (!w_ireq)                           r_starve <= '0;
            else if (r_starve != SW'(STARVE_LIMIT)) r_starve <= r_starve + SW'(1);
            r_state   <= SERVE_D;
          end
        end
        SERVE_I, SERVE_D: begin
          if (w_done) begin
            // A real bus_ack on the expiry edge still wins over the abort.
            bus_cs  <= 1'b0;
            bus_err <= ~bus_ack;
            if (r_state == SERVE_I) begin
              inst_ack  <= 1'b1;
              inst_data <= bus_ack ? bus_rdata : DATA_W'(ARB_ERR_DATA);
            end else begin
              mem_ack <= 1'b1;
              mem_din <= bus_ack ? bus_rdata : DATA_W'(ARB_ERR_DATA);
            end
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomised scoreboard bench for unified_mem_arbiter: requester tasks push
// expectations, a bus slave model serves the port, a monitor checks acks.
module tb_unified_mem_arbiter;

  localparam int AW = 32, DW = 32, SL = 4, TO = 255;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          inst_ren = 0, mem_ren = 0, mem_wen = 0, bus_ack = 0;
  logic [AW-1:0] inst_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_dout = '0, bus_rdata = '0;
  logic [DW-1:0] inst_data, mem_din, bus_wdata;
  logic [AW-1:0] bus_addr;
  logic          inst_ack, mem_ack, bus_cs, bus_we, stall, bus_err;

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_ack(inst_ack),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_ack(mem_ack),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall(stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic err; logic chk; } exp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wd; } bus_t;

  exp_t        iq[$], dq[$];
  logic [31:0] bus_iq[$];
  bus_t        bus_dq[$];
  logic [31:0] ref_mem[int], slv_mem[int];

  int   n_chk = 0, n_fail = 0, cyc = 0, last_ack = -100, sc = 0, cs_cnt = 0;
  int   lat_force = -1, g_n = 0;
  logic slv_hang = 0, s_ireq = 0, s_dreq = 0;
  logic [15:0] g_bits = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc++;
    s_ireq = inst_ren;
    s_dreq = mem_ren | mem_wen;
  end

  always @(negedge rst_n) begin
    sc = 0;
    last_ack = -100;
  end

  // Bus slave plus arbitration-order reference.
  int          wcnt = 0, lat = 0;
  logic        cs_seen = 0, w_fetch;
  logic [31:0] cur_addr, cur_wd;
  logic        cur_we;
  always @(negedge clk) begin
    if (!rst_n) begin
      bus_ack = 0;
      cs_seen = 0;
    end else if (bus_ack) begin
      bus_ack = 0;
    end else if (!bus_cs) begin
      cs_seen = 0;
    end else begin
      if (!cs_seen) begin
        cs_seen = 1; cs_cnt = 1; wcnt = 0;
        lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
        cur_addr = bus_addr; cur_we = bus_we; cur_wd = bus_wdata;
        check("turnaround_ok", (cyc - last_ack) >= 2, 1'b1);
        check("grant_has_req", s_ireq | s_dreq, 1'b1);
        w_fetch = (s_ireq && s_dreq) ? (sc == SL) : s_ireq;
        if (w_fetch) begin
          if (bus_iq.size() == 0) check("fetch_bus_expected", 1'b0, 1'b1);
          else check("fetch_bus", {bus_addr, bus_we}, {bus_iq[0], 1'b0});
          sc = 0;
        end else begin
          if (bus_dq.size() == 0) check("data_bus_expected", 1'b0, 1'b1);
          else check("data_bus", {bus_addr, 31'b0, bus_we, bus_we ? bus_wdata : 32'h0},
                     {bus_dq[0].addr, 31'b0, bus_dq[0].we, bus_dq[0].we ? bus_dq[0].wd : 32'h0});
          sc = s_ireq ? ((sc < SL) ? sc + 1 : SL) : 0;
        end
        g_bits = {g_bits[14:0], w_fetch};
        g_n++;
      end else begin
        cs_cnt++;
        check("bus_hold", {bus_addr, 31'b0, bus_we, bus_wdata}, {cur_addr, 31'b0, cur_we, cur_wd});
      end
      if (!slv_hang && wcnt == lat) begin
        bus_ack = 1;
        if (cur_we) slv_mem[cur_addr] = cur_wd;
        bus_rdata = cur_we ? $urandom : slv_rd(cur_addr);
        cs_seen = 0;
      end else wcnt++;
    end
  end

  // Response monitor.
  exp_t e;
  always @(negedge clk) begin
    check("stall", stall, (inst_ren & ~inst_ack) | ((mem_ren | mem_wen) & ~mem_ack));
    check("err_without_ack", bus_err & ~(inst_ack | mem_ack), 1'b0);
    check("dual_ack", inst_ack & mem_ack, 1'b0);
    if (inst_ack) begin
      last_ack = cyc;
      if (iq.size() == 0) check("inst_ack_expected", 1'b0, 1'b1);
      else begin
        e = iq.pop_front();
        if (e.chk) check("inst_data", inst_data, e.data);
        check("inst_err", bus_err, e.err);
      end
      if (bus_iq.size() != 0) void'(bus_iq.pop_front());
    end
    if (mem_ack) begin
      last_ack = cyc;
      if (dq.size() == 0) check("mem_ack_expected", 1'b0, 1'b1);
      else begin
        e = dq.pop_front();
        if (e.chk) check("mem_din", mem_din, e.data);
        check("mem_err", bus_err, e.err);
        if (e.err) check("timeout_wait_cycles", cs_cnt, TO);
      end
      if (bus_dq.size() != 0) void'(bus_dq.pop_front());
    end
  end

  task automatic do_fetch(input logic [31:0] a, output int lt);
    exp_t x;
    @(posedge clk); #1;
    x.err = slv_hang; x.chk = 1'b1;
    x.data = slv_hang ? 32'hDEAD_BEEF : ref_rd(a);
    iq.push_back(x);
    bus_iq.push_back(a);
    inst_addr = a; inst_ren = 1;
    lt = 0;
    do begin @(negedge clk); lt++; end while (!inst_ack && lt < 1000);
    if (!inst_ack) check("fetch_ack_in_time", 1'b0, 1'b1);
    #1 inst_ren = 0;
  endtask

  task automatic do_data(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, output int lt);
    exp_t x;
    bus_t b;
    @(posedge clk); #1;
    x.err = slv_hang; x.chk = ~w;
    x.data = slv_hang ? 32'hDEAD_BEEF : ref_rd(a);
    if (w && !slv_hang) ref_mem[a] = d;
    dq.push_back(x);
    b.addr = a; b.we = w; b.wd = d;
    bus_dq.push_back(b);
    mem_addr = a; mem_dout = d; mem_ren = r; mem_wen = w;
    lt = 0;
    do begin @(negedge clk); lt++; end while (!mem_ack && lt < 1000);
    if (!mem_ack) check("data_ack_in_time", 1'b0, 1'b1);
    #1 begin mem_ren = 0; mem_wen = 0; end
  endtask

  task automatic rand_fetch(input int n);
    int lt;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_fetch(32'($urandom_range(0, 1023)) << 2, lt);
    end
  endtask

  task automatic rand_data(input int n);
    int lt, op;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = int'($urandom_range(0, 2));
      do_data(op != 1, op != 0, 32'h8000 | (32'($urandom_range(0, 15)) << 2), $urandom, lt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lt, lt2;
    #1 rst_n = 0;
    #20;
    check("rst_bus_cs", bus_cs, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_acks", {inst_ack, mem_ack, bus_err, stall}, 4'b0);
    check("rst_data", {inst_data, mem_din}, 64'h0);
    check("rst_bus_addr_wdata", {bus_addr, bus_wdata}, 64'h0);
    @(posedge clk); #3 rst_n = 1;

    // Fetch only, zero-wait slave.
    ref_mem[32'h40] = 32'h2008_0005; slv_mem[32'h40] = 32'h2008_0005;
    lat_force = 0;
    do_fetch(32'h40, lt);
    check("fetch_latency", lt, 3);

    // Simultaneous requests: data first, then fetch.
    g_n = 0;
    fork
      do_fetch(32'h44, lt);
      do_data(1, 0, 32'h100, 0, lt2);
    join
    check("simul_order", {g_n[7:0], g_bits[1:0]}, {8'd2, 2'b01});

    // Write with a few wait states.
    lat_force = 2;
    do_data(0, 1, 32'h200, 32'hA5A5_A5A5, lt);
    check("write_latency", lt, 5);
    do_data(1, 0, 32'h200, 0, lt);

    // Starvation: fetch held while data streams back to back.
    lat_force = 0;
    do_data(1, 0, 32'h104, 0, lt);
    g_n = 0;
    fork
      do_fetch(32'h48, lt);
      for (int i = 0; i < 6; i++) do_data(1, 0, 32'h110 + 32'(i * 4), 0, lt2);
    join
    check("starve_order", {g_n[7:0], g_bits[6:0]}, {8'd7, 7'b0000100});

    // Bus timeout.
    slv_hang = 1;
    do_data(1, 0, 32'h300, 0, lt);
    slv_hang = 0;
    do_data(1, 0, 32'h304, 0, lt);

    // Asynchronous reset mid data access, request held through it.
    lat_force = 20;
    fork
      do_data(1, 0, 32'h180, 0, lt);
      begin
        int k = 0;
        do begin @(negedge clk); k++; end while (!bus_cs && k < 50);
        repeat (3) @(negedge clk);
        check("pre_reset_cs", bus_cs, 1'b1);
        #2 rst_n = 0;
        #1;
        check("async_rst_cs", bus_cs, 1'b0);
        check("async_rst_acks", {inst_ack, mem_ack, bus_err}, 3'b0);
        lat_force = 1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
      end
    join
    lat_force = -1;

    // Randomised concurrent traffic.
    fork
      rand_fetch(40);
      rand_data(40);
    join
    repeat (5) @(posedge clk);
    check("iq_drained", iq.size(), 0);
    check("dq_drained", dq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the pipeline's instruction-fetch port and its data port.
- Sits between the CPU datapath memory signals and the memory/bus wrapper.
- Serialises accesses, returns each access's data to the correct requester, and raises a stall while any enabled request is outstanding.
- Has a starvation guard and a bus timeout.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch is pending before fetch is forced.
- TIMEOUT, 255, bus-wait cycles without bus_ack before the access is aborted (8-bit counter; must be 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- inst_ren  in  1  fetch request (level)
- inst_addr  in  ADDR_W  fetch address
- inst_data  out  DATA_W  fetched word (valid with inst_ack)
- inst_ack  out  1  one-cycle fetch completion pulse
- mem_ren  in  1  data read request (level)
- mem_wen  in  1  data write request (level)
- mem_addr  in  ADDR_W  data address
- mem_dout  in  DATA_W  write data from datapath
- mem_din  out  DATA_W  load data to datapath (valid with mem_ack)
- mem_ack  out  1  one-cycle data completion pulse
- bus_cs  out  1  memory select
- bus_we  out  1  memory write enable
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  DATA_W  memory write data
- bus_rdata  in  DATA_W  memory read data
- bus_ack  in  1  memory completion
- stall  out  1  combinational: (inst_ren & ~inst_ack) | ((mem_ren|mem_wen) & ~mem_ack)
- bus_err  out  1  one-cycle pulse when an access times out

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; starvation and timeout counters 0.
- Reset is asynchronous. Asserting it mid-access drops bus_cs immediately and abandons the access with no ack.
- FSM states: IDLE, SERVE_I, SERVE_D, DONE.
- Request masking: a requester whose ack is high this cycle is treated as not requesting.
- IDLE grant rule:
  - Data (read or write) wins over fetch, unless starve_cnt==STARVE_LIMIT and inst_ren is high; then fetch wins.
  - No request: stay in IDLE.
- On grant at edge N:
  - Register bus_addr, bus_we (=mem_wen for data, 0 for fetch), bus_wdata, and bus_cs=1.
  - Go to SERVE_I or SERVE_D.
  - bus_cs is first visible in cycle N+1.
- mem_ren & mem_wen together: performed as a write. mem_din is undefined, mem_ack is still pulsed.
- SERVE_x: bus outputs are held stable. The timeout counter increments each cycle without bus_ack.
- bus_ack sampled at edge M:
  - Capture bus_rdata into inst_data or mem_din.
  - Pulse the matching ack during cycle M+1; drop bus_cs; go to DONE; clear the timeout counter.
  - Minimum latency from request to ack: 2 cycles (request seen at edge N, bus_ack in cycle N+1, ack in cycle N+2).
- Timeout: counter reaching TIMEOUT with no bus_ack aborts the access.
  - Return data is 32'hDEAD_BEEF.
  - The matching ack is pulsed together with bus_err.
  - Then go to DONE.
- DONE: go to IDLE unconditionally. The next bus_cs is at the earliest 2 cycles after the previous ack, giving a one-cycle bus turnaround.
- Starvation counter:
  - Increments on each data grant made while inst_ren is high; saturates at STARVE_LIMIT.
  - Clears on every fetch grant.
  - Clears on a data grant made while inst_ren is low.
- Output data registers hold their last value between acks.
- Request stability: requesters hold address, data, and request until their ack. Changes mid-access are ignored because bus outputs are registered at grant.

Decomposition:
- Shared package arb_pkg:
  - state encoding (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2, DONE=2'd3)
  - ARB_ERR_DATA=32'hDEAD_BEEF
  - width of the timeout counter
- One sub-module, arb_wait_timer: clear/enable/expire counter with parameter TIMEOUT, reused for the bus timeout.

Test Plan:
- Fetch only: inst_ren=1, inst_addr=0x40; bus_ack one cycle after bus_cs with bus_rdata=0x2008_0005 -> bus_cs=1 with bus_addr=0x40 and bus_we=0; inst_ack pulses one cycle with inst_data=0x2008_0005; stall drops in the ack cycle.
- Simultaneous requests: inst_ren=1 (addr 0x44) and mem_ren=1 (addr 0x100) in the same cycle -> data served first; fetch bus_cs begins 2 cycles after mem_ack; both acks are seen exactly once.
- Write: mem_wen=1, mem_addr=0x200, mem_dout=0xA5A5_A5A5 -> bus_we=1, bus_wdata=0xA5A5_A5A5 held until bus_ack; mem_ack pulses.
- Starvation: inst_ren held high and data requests back-to-back, STARVE_LIMIT=4 -> the 5th grant goes to fetch, and the counter restarts.
- Timeout: mem_ren=1, bus_ack never asserted -> after 255 wait cycles, mem_ack and bus_err pulse together with mem_din=0xDEAD_BEEF; FSM returns to IDLE.
- Async reset mid-access: rst_n low while in SERVE_D -> bus_cs, acks, and stall-related registers are 0 immediately without waiting for clk; after release, pending requests are re-arbitrated from IDLE.
